// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and frame timing for the UART receive controller.
package uart_pkg;
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_RUN = 2'd1, ST_STOP = 2'd2} state_t;
  localparam int OVERSAMPLE  = 16;
  localparam int FRAME_TICKS = 10 * OVERSAMPLE;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divisor latch and counter producing a 1-clk oversample tick every div_q+1 clocks.
module uart_baud_gen #(
  parameter int DIV_W = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_cnt;
  assign o_tick = i_run && r_cnt == r_div_q;
  // a zero divisor would hold the tick high, so the shortest period is clamped to 2 clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_q <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_div_q <= (i_div == '0) ? DIV_W'(1) : i_div;
      r_cnt   <= '0;
    end else if (i_run) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences a 16x-oversampled UART receiver and buffers bytes in an FWFT FIFO.
// Optional idle-timeout interrupt built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
`ifdef UART_RX_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CHARS = 4
`endif
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic [DIV_W-1:0]              i_div,
  input  logic                          i_rx_pin,
  output logic                          o_rx_sync,
  output logic                          o_s_tick,
  input  logic [7:0]                    i_rx_dout,
  input  logic                          i_rx_done,
  input  logic                          i_rd_en,
  output logic [7:0]                    o_rd_data,
  output logic                          o_rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overrun,
  input  logic                          i_ovr_clr,
  output logic                          o_timeout_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  state_t        r_state;
  logic [1:0]    r_rx_s;
  logic [1:0]    r_done_s;
  logic          r_done_d;
  logic [7:0]    r_idle;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          r_overrun;
  logic          w_tick;
  logic          w_rise;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (r_state == ST_OFF && i_en),
    .i_run  (r_state != ST_OFF),
    .i_div  (i_div),
    .o_tick (w_tick)
  );
  assign w_rise        = r_done_s[1] & ~r_done_d;
  assign w_full        = r_count == CW'(FIFO_DEPTH);
  assign w_pop         = i_rd_en && r_count != '0;
  assign w_push        = w_rise && (!w_full || w_pop);
  assign o_s_tick      = w_tick;
  assign o_rx_sync     = (r_state == ST_OFF) | r_rx_s[1];
  assign o_rd_valid    = r_count != '0;
  assign o_rd_data     = o_rd_valid ? r_mem[r_rp] : 8'h00;
  assign o_fifo_count  = r_count;
  assign o_overrun     = r_overrun;
  // STOP drains the byte in flight: leave on its rx_done, or after a full idle frame of ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_rx_s   <= 2'b11;
      r_done_s <= 2'b00;
      r_done_d <= 1'b0;
      r_idle   <= '0;
    end else begin
      r_rx_s   <= {r_rx_s[0], i_rx_pin};
      r_done_s <= {r_done_s[0], i_rx_done};
      r_done_d <= r_done_s[1];
      r_idle   <= (r_state != ST_STOP || !r_rx_s[1]) ? '0 : r_idle + 8'(w_tick);
      case (r_state)
        ST_OFF:  r_state <= i_en ? ST_RUN : ST_OFF;
        ST_RUN:  r_state <= i_en ? ST_RUN : ST_STOP;
        default: r_state <= i_en ? ST_RUN :
                            (w_rise || (w_tick && r_rx_s[1] && r_idle == 8'(FRAME_TICKS - 1))) ? ST_OFF : ST_STOP;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_rx_dout;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_wp      <= r_wp + AW'(w_push);
      r_rp      <= r_rp + AW'(w_pop);
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      r_overrun <= (w_rise && w_full && !w_pop) | (r_overrun & ~i_ovr_clr);
    end
  end
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TO_TICKS = TIMEOUT_CHARS * FRAME_TICKS;
  localparam int TW       = $clog2(TO_TICKS + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_to_irq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_to_irq <= 1'b0;
    end else if (w_push || w_pop) begin
      r_to_cnt <= '0;
      r_to_irq <= 1'b0;
    end else if (o_rd_valid && w_tick && !r_to_irq) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      r_to_irq <= r_to_cnt == TW'(TO_TICKS - 1);
    end
  end
  assign o_timeout_irq = r_to_irq;
`else
  assign o_timeout_irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench; expected bytes queued at send, popped by a monitor on each FIFO read.
module tb_uart_rx_ctrl;
  localparam int D = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div = '0;
  logic        rx_pin = 1'b1;
  logic [7:0]  rx_dout = '0;
  logic        rx_done = 1'b0;
  logic        rd_dir = 1'b0;
  logic        rd_rand = 1'b0;
  logic        rd_bit = 1'b0;
  logic        rd_en;
  logic        ovr_clr = 1'b0;
  logic        rx_sync, s_tick, rd_valid, overrun, irq;
  logic [7:0]  rd_data;
  logic [2:0]  count;
  int          n_chk = 0;
  int          n_fail = 0;
  byte unsigned exp_q[$];
  logic        exp_ovr = 1'b0;
  assign rd_en = rd_dir | (rd_rand & rd_bit);
  always #5 clk = ~clk;
  uart_rx_ctrl #(.FIFO_DEPTH(D), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_div(div), .i_rx_pin(rx_pin),
    .o_rx_sync(rx_sync), .o_s_tick(s_tick), .i_rx_dout(rx_dout), .i_rx_done(rx_done),
    .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_fifo_count(count),
    .o_overrun(overrun), .i_ovr_clr(ovr_clr), .o_timeout_irq(irq)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: every accepted pop is compared against the oldest expected byte
  always @(negedge clk) begin
    if (rst_n && rd_en && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected none", rd_data);
      end else begin
        chk("pop_data", rd_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end
  always @(posedge clk) begin
    #1 rd_bit = 1'($urandom_range(0, 1));
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dout = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    if (exp_q.size() < D) exp_q.push_back(b);
    else exp_ovr = 1'b1;
    pulse(b);
    cyc(4);
  endtask
  task automatic pop();
    rd_dir = 1'b1;
    cyc(1);
    rd_dir = 1'b0;
  endtask
  task automatic count_ticks(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (s_tick) c++;
    end
    #1;
  endtask
  task automatic period(input string name, input int n, input int exp);
    int last;
    last = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (s_tick) begin
        if (last >= 0) chk(name, i - last, exp);
        last = i;
      end
    end
    chk({name, "_seen"}, last >= 0, 1);
    #1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_sync"}, rx_sync, 1);
    chk({tag, "_s_tick"}, s_tick, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_irq"}, irq, 0);
  endtask
  initial begin
    int c;
    logic [7:0] b;
    #2;
    chk_reset_outputs("reset");
    cyc(2);
    rst_n = 1'b1;
    count_ticks(20, c);
    chk("off_no_ticks", c, 0);
    // tick period and synchroniser latency
    div = 16'd3;
    en = 1'b1;
    period("tick_period_div3", 40, 4);
    rx_pin = 1'b0;
    cyc(1);
    chk("rx_sync_lat1", rx_sync, 1);
    cyc(1);
    chk("rx_sync_lat2", rx_sync, 0);
    rx_pin = 1'b1;
    cyc(3);
    // single byte with push latency
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    rx_dout = 8'hA5;
    rx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
    chk("push_lat1_valid", rd_valid, 0);
    cyc(1);
    chk("push_lat2_valid", rd_valid, 0);
    cyc(1);
    chk("push_lat3_valid", rd_valid, 1);
    chk("push_lat3_data", rd_data, 8'hA5);
    chk("push_lat3_count", count, 1);
    pop();
    chk("after_pop_count", count, 0);
    chk("after_pop_valid", rd_valid, 0);
    pop();
    chk("empty_pop_count", count, 0);
    // overflow
    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("full_count", count, D);
    chk("overrun_set", overrun, exp_ovr);
    for (int i = 0; i < D; i++) pop();
    chk("drained_count", count, 0);
    chk("overrun_sticky", overrun, 1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);
    exp_ovr = 1'b0;
    for (int i = 0; i < D; i++) send(8'($urandom_range(0, 255)));
    chk("refill_count", count, D);
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    pulse(b);
    cyc(1);
    rd_dir = 1'b1;
    cyc(1);
    rd_dir = 1'b0;
    cyc(1);
    chk("pushpop_full_count", count, D);
    chk("pushpop_full_overrun", overrun, 0);
    // overrun set in the same cycle as a clear: set must win
    pulse(8'hEE);
    cyc(1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    cyc(1);
    chk("set_beats_clear", overrun, 1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    for (int i = 0; i < D; i++) pop();
    chk("drain2_count", count, 0);
    // div change during RUN ignored; STOP keeps ticking until rx_done
    div = 16'd7;
    period("div_not_applied", 40, 4);
    rx_pin = 1'b0;
    en = 1'b0;
    count_ticks(40, c);
    chk("stop_ticks", c, 10);
    send(8'h3C);
    count_ticks(20, c);
    chk("off_after_done_ticks", c, 0);
    chk("off_rx_sync_forced", rx_sync, 1);
    chk("off_byte_count", count, 1);
    pop();
    rx_pin = 1'b1;
    en = 1'b1;
    period("relatch_div7", 40, 8);
    en = 1'b0;
    cyc(10);
    div = 16'd2;
    en = 1'b1;
    period("stop_to_run_keeps_div", 40, 8);
    en = 1'b0;
    count_ticks(400, c);
    chk("idle_stop_ticks", c, 50);
    cyc(1000);
    count_ticks(40, c);
    chk("idle_exit_no_ticks", c, 0);
    // asynchronous reset mid-frame
    en = 1'b1;
    send(8'h11);
    rx_pin = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    exp_ovr = 1'b0;
    #10;
    rst_n = 1'b1;
    rx_pin = 1'b1;
    cyc(3);
    send(8'h5A);
    chk("post_reset_count", count, 1);
    pop();
    chk("post_reset_empty", count, 0);
    // randomised traffic with a random consumer
    rd_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (exp_q.size() < D) send(8'($urandom_range(0, 255)));
      else cyc(3);
    end
    c = 0;
    while ((exp_q.size() != 0 || rd_valid) && c < 200) begin
      cyc(1);
      c++;
    end
    rd_rand = 1'b0;
    chk("random_model_empty", exp_q.size(), 0);
    chk("random_dut_empty", count, 0);
    chk("random_no_overrun", overrun, 0);
    // idle timeout with div=0 clamped to a 2 clk period
    rst_n = 1'b0;
    div = 16'd0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    send(8'h77);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    cyc(1200);
    chk("irq_not_early", irq, 0);
    c = 0;
    while (!irq && c < 200) begin
      cyc(1);
      c++;
    end
    chk("irq_set", irq, 1);
    pop();
    chk("irq_cleared_by_pop", irq, 0);
`else
    cyc(1500);
    chk("irq_tied_low", irq, 0);
    pop();
`endif
    chk("final_count", count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
